inst_fetch_decode: RTL and testbench

INST_FETCH_DECODE -- requirements
Module: inst_fetch_decode

---
 rtl/inst_fetch_decode.sv | 134 +++++++++++++
 tb/tb_inst_fetch_decode.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_decode.sv
// rtl/inst_fetch_decode.sv - instruction fetch and decode stage with valid/ready output register
//
// Fetches one 16-bit instruction per cycle from a combinational ROM addressed by
// pc, latches it together with its address into an output register, and decodes
// fields and class flags from that register.
//
// Optional feature: define FETCH_PERF_CNT_EN to add a saturating issue counter.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   run                 fetch enable
//   rom_addr, rom_inst  ROM address (equals pc) and same-cycle ROM data
//   pc_wr_en/pc_wr_data PC redirect from execute; flushes the output register
//   dec_valid/dec_ready output handshake
//   dec_pc              address of the held instruction
//   dec_opcode, dec_dest, dec_op1, dec_op2, dec_const  instruction fields
//   dec_wr_reg, dec_mem_rd, dec_mem_wr, dec_branch, dec_pc_write  class flags
//   issue_cnt           transfers issued, saturating (FETCH_PERF_CNT_EN only)

module inst_fetch_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_inst,
  input  logic        pc_wr_en,
  input  logic [7:0]  pc_wr_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [7:0]  dec_pc,
  output logic [3:0]  dec_opcode,
  output logic [3:0]  dec_dest,
  output logic [3:0]  dec_op1,
  output logic [3:0]  dec_op2,
  output logic [7:0]  dec_const,
  output logic        dec_wr_reg,
  output logic        dec_mem_rd,
  output logic        dec_mem_wr,
  output logic        dec_branch,
  output logic        dec_pc_write
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] issue_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  pc;
  logic [15:0] inst;
  logic        capture;
  logic        xfer;
  logic        wr_class;

  assign rom_addr = pc;

  // A redirect wins over everything, so it also suppresses capture.
  always_comb begin
    xfer    = dec_valid && dec_ready;
    capture = !pc_wr_en && run && (state != IDLE) && (!dec_valid || dec_ready);
  end

  always_comb begin
    state_nxt = state;
    if (pc_wr_en) begin
      state_nxt = run ? RUN : IDLE;
    end else if (!run && (!dec_valid || dec_ready)) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (run) state_nxt = RUN;
        RUN:     if (dec_valid && !dec_ready) state_nxt = HOLD;
        HOLD:    if (dec_ready) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= 8'h00;
      dec_valid <= 1'b0;
      dec_pc    <= 8'h00;
      inst      <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (pc_wr_en) begin
        pc        <= pc_wr_data;
        dec_valid <= 1'b0;
      end else if (capture) begin
        inst      <= rom_inst;
        dec_pc    <= pc;
        pc        <= pc + 8'd1;
        dec_valid <= 1'b1;
      end else if (xfer) begin
        dec_valid <= 1'b0;
      end
    end
  end

  assign dec_opcode = inst[15:12];
  assign dec_dest   = inst[11:8];
  assign dec_op1    = inst[7:4];
  assign dec_op2    = inst[3:0];
  assign dec_const  = inst[7:0];

  always_comb begin
    wr_class = 1'b0;
    case (dec_opcode)
      4'd1, 4'd3, 4'd4, 4'd5: wr_class = 1'b1;
      default:                wr_class = dec_opcode[3];
    endcase
  end

  // Flags are meaningless without a held instruction, so they are gated by dec_valid.
  assign dec_wr_reg   = dec_valid && wr_class;
  assign dec_mem_rd   = dec_valid && (dec_opcode == 4'd1);
  assign dec_mem_wr   = dec_valid && (dec_opcode == 4'd2);
  assign dec_branch   = dec_valid && ((dec_opcode == 4'd6) || (dec_opcode == 4'd7));
  assign dec_pc_write = dec_wr_reg && (dec_dest == 4'd0);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= 16'h0000;
    end else if (xfer && (issue_cnt != 16'hFFFF)) begin
      issue_cnt <= issue_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_decode.sv
// tb/tb_inst_fetch_decode.sv - directed scoreboard bench for inst_fetch_decode

module tb_inst_fetch_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_inst;
  logic        pc_wr_en = 1'b0;
  logic [7:0]  pc_wr_data = 8'h00;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [7:0]  dec_pc;
  logic [3:0]  dec_opcode, dec_dest, dec_op1, dec_op2;
  logic [7:0]  dec_const;
  logic        dec_wr_reg, dec_mem_rd, dec_mem_wr, dec_branch, dec_pc_write;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] issue_cnt;
`endif

  logic [15:0] rom [256];
  logic [4:0]  flags_o;

  assign rom_inst = rom[rom_addr];
  assign flags_o  = {dec_wr_reg, dec_mem_rd, dec_mem_wr, dec_branch, dec_pc_write};

  always #5 clk = ~clk;

  inst_fetch_decode dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .rom_addr     (rom_addr),
    .rom_inst     (rom_inst),
    .pc_wr_en     (pc_wr_en),
    .pc_wr_data   (pc_wr_data),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_pc       (dec_pc),
    .dec_opcode   (dec_opcode),
    .dec_dest     (dec_dest),
    .dec_op1      (dec_op1),
    .dec_op2      (dec_op2),
    .dec_const    (dec_const),
    .dec_wr_reg   (dec_wr_reg),
    .dec_mem_rd   (dec_mem_rd),
    .dec_mem_wr   (dec_mem_wr),
    .dec_branch   (dec_branch),
    .dec_pc_write (dec_pc_write)
`ifdef FETCH_PERF_CNT_EN
    ,
    .issue_cnt    (issue_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] inst;
    logic [4:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   xfers  = 0;
  bit   sb_en  = 1'b1;

  // Flags {wr_reg, mem_rd, mem_wr, branch, pc_write} from the opcode table.
  function automatic logic [4:0] model_flags(input logic [15:0] i);
    logic [3:0] op;
    logic       wr;
    op = i[15:12];
    wr = (op == 4'd1) || (op == 4'd3) || (op == 4'd4) || (op == 4'd5) || (op >= 4'd8);
    return {wr, op == 4'd1, op == 4'd2, (op == 4'd6) || (op == 4'd7), wr && (i[11:8] == 4'd0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic push_exp(input logic [7:0] a);
    exp_t e;
    e.pc    = a;
    e.inst  = rom[a];
    e.flags = model_flags(rom[a]);
    sb.push_back(e);
  endtask

  task automatic check_xfer();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("xfer_pc",    dec_pc, e.pc);
      chk("xfer_inst",  {dec_opcode, dec_dest, dec_op1, dec_op2}, e.inst);
      chk("xfer_const", dec_const, e.inst[7:0]);
      chk("xfer_flags", flags_o, e.flags);
    end
  endtask

  // Outputs are observed on the falling edge; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    if (dec_valid && dec_ready) begin
      xfers++;
      if (sb_en) check_xfer();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[8'h00] = 16'h32FF;
    rom[8'h01] = 16'h3000;
    rom[8'h02] = 16'h2210;
    rom[8'h03] = 16'h0000;
    rom[8'h04] = 16'h1123;
    rom[8'h05] = 16'h6ABC;
    rom[8'hFE] = 16'h7001;
    rom[8'hFF] = 16'h8000;

    // Reset is asynchronous: values must be cleared before any clock edge.
    #2;
    chk("rst_valid",   dec_valid, 1'b0);
    chk("rst_romaddr", rom_addr,  8'h00);
    chk("rst_decpc",   dec_pc,    8'h00);
    chk("rst_fields",  {dec_opcode, dec_dest, dec_op1, dec_op2}, 16'h0000);
    chk("rst_flags",   flags_o,   5'b0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b1;
    dec_ready = 1'b1;
    for (int a = 0; a < 5; a++) push_exp(8'(a));

    step();
    chk("idle_to_run_valid", dec_valid, 1'b0);

    step();
    chk("first_valid",   dec_valid,  1'b1);
    chk("first_pc",      dec_pc,     8'h00);
    chk("first_opcode",  dec_opcode, 4'd3);
    chk("first_dest",    dec_dest,   4'd2);
    chk("first_const",   dec_const,  8'hFF);
    chk("first_wr_reg",  dec_wr_reg, 1'b1);
    chk("first_romaddr", rom_addr,   8'h01);

    step();
    chk("set_r0_pc",       dec_pc,       8'h01);
    chk("set_r0_pc_write", dec_pc_write, 1'b1);

    step();
    chk("store_mem_wr",   dec_mem_wr,   1'b1);
    chk("store_wr_reg",   dec_wr_reg,   1'b0);
    chk("store_pc_write", dec_pc_write, 1'b0);

    step();
    chk("nop_valid", dec_valid, 1'b1);
    chk("nop_flags", flags_o,   5'b0);

    step();
    chk("pre_stall_pc", dec_pc, 8'h04);

    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid",   dec_valid, 1'b1);
      chk("stall_pc",      dec_pc,    8'h04);
      chk("stall_romaddr", rom_addr,  8'h05);
      chk("stall_inst",    {dec_opcode, dec_dest, dec_op1, dec_op2}, 16'h1123);
      chk("stall_flags",   flags_o,   5'b11000);
    end
    dec_ready = 1'b1;
    step();
    chk("resume_pc",      dec_pc,   8'h05);
    chk("resume_romaddr", rom_addr, 8'h06);

    // Redirect while stalled discards the held instruction.
    dec_ready  = 1'b0;
    pc_wr_en   = 1'b1;
    pc_wr_data = 8'h00;
    step();
    chk("redir_valid",   dec_valid, 1'b0);
    chk("redir_romaddr", rom_addr,  8'h00);
    pc_wr_en  = 1'b0;
    dec_ready = 1'b1;
    push_exp(8'h00);
    step();
    chk("redir_cap_pc",    dec_pc,    8'h00);
    chk("redir_cap_valid", dec_valid, 1'b1);

    // PC wrap from 0xFF to 0x00.
    pc_wr_en   = 1'b1;
    pc_wr_data = 8'hFE;
    push_exp(8'hFE);
    push_exp(8'hFF);
    push_exp(8'h00);
    push_exp(8'h01);
    step();
    chk("wrap_redir_valid", dec_valid, 1'b0);
    chk("wrap_romaddr_fe",  rom_addr,  8'hFE);
    pc_wr_en = 1'b0;
    step();
    step();
    chk("wrap_pc_ff",      dec_pc,   8'hFF);
    chk("wrap_romaddr_00", rom_addr, 8'h00);
    step();
    step();
    chk("wrap_pc_01", dec_pc, 8'h01);

    // Stop fetching: last instruction is consumed and flags are forced low.
    run = 1'b0;
    step();
    chk("stop_valid",   dec_valid, 1'b0);
    chk("stop_flags",   flags_o,   5'b0);
    chk("stop_romaddr", rom_addr,  8'h02);
    step();
    chk("idle_romaddr", rom_addr,  8'h02);
    chk("idle_valid",   dec_valid, 1'b0);

    // Reset in the middle of a cycle while an instruction is held.
    run = 1'b1;
    dec_ready = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_pc",    dec_pc,    8'h02);
    chk("pre_rst_valid", dec_valid, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    chk("cnt_count", issue_cnt, 16'(xfers));
`endif
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_valid",   dec_valid, 1'b0);
    chk("midrst_romaddr", rom_addr,  8'h00);
    chk("midrst_pc",      dec_pc,    8'h00);
    chk("midrst_flags",   flags_o,   5'b0);
    chk("midrst_opcode",  dec_opcode, 4'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_cnt", issue_cnt, 16'h0000);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    dec_ready = 1'b1;
    push_exp(8'h00);
    push_exp(8'h01);
    step();
    step();
    chk("post_rst_pc", dec_pc, 8'h00);
    step();
    run = 1'b0;
    step();
    chk("post_rst_valid", dec_valid, 1'b0);
    chk("sb_drained", sb.size(), 0);

`ifdef FETCH_PERF_CNT_EN
    sb_en = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 70010; i++) step();
    chk("cnt_saturate", issue_cnt, 16'hFFFF);
    #3;
    rst = 1'b1;
    #1;
    chk("sat_rst_cnt",   issue_cnt, 16'h0000);
    chk("sat_rst_valid", dec_valid, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
